// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN calculator: command opcodes and the
// execution-stage FSM state encoding.
package rpn_pkg;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_PUSH  = 3'd1;
   localparam logic [2:0] OP_POP   = 3'd2;
   localparam logic [2:0] OP_ADD   = 3'd3;
   localparam logic [2:0] OP_SUB   = 3'd4;
   localparam logic [2:0] OP_MUL   = 3'd5;
   localparam logic [2:0] OP_DUP   = 3'd6;
   localparam logic [2:0] OP_CLEAR = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD_A = 2'd1,
      ST_RD_B = 2'd2,
      ST_WB   = 2'd3
   } rpn_state_t;

endpackage

// File: rtl/rpn_stack_ram.sv
// Single-port operand stack memory, DEPTH x DATA_W, one-cycle synchronous
// read. No reset: entries are always written before being read.
module rpn_stack_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic [PTR_W-1:0]  addr,
   input  logic              we,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/rpn_exec.sv
// RPN calculator execution stage: owns the operand stack, the stack pointer,
// a cached top-of-stack and sticky error flags.
module rpn_exec
   import rpn_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic              CLOCK_50,
   input  logic              RESET_N,
   // Handshake: a command is taken on a rising edge with cmd_valid && cmd_ready;
   // cmd_op/cmd_data are sampled only on that edge, cmd_ready is high only in IDLE.
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_data,
   output logic [DATA_W-1:0] top,
   output logic [PTR_W:0]    depth,
   output logic              err_overflow,
   output logic              err_underflow,
   output rpn_state_t        dbg_state,
   output logic [DATA_W-1:0] dbg_next
);

   localparam logic [PTR_W:0] D_ONE   = (PTR_W+1)'(1);
   localparam logic [PTR_W:0] D_TWO   = (PTR_W+1)'(2);
   localparam logic [PTR_W:0] D_THREE = (PTR_W+1)'(3);
   localparam logic [PTR_W:0] D_FULL  = (PTR_W+1)'(DEPTH);

   rpn_state_t        state_q, state_d;
   logic [PTR_W:0]    depth_q, depth_d;
   logic [DATA_W-1:0] top_q, top_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [2:0]        op_q, op_d;
   logic [DATA_W-1:0] opa_q, opa_d;
   logic [DATA_W-1:0] opb_q, opb_d;
   logic [DATA_W-1:0] next_q, next_d;

   logic [PTR_W-1:0]  ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic [DATA_W-1:0] alu_res;
   logic [PTR_W:0]    depth_m2;
   logic [PTR_W:0]    depth_m3;
   logic              is_full;
   logic              is_empty;

   rpn_stack_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_ram (
      .clk   (CLOCK_50),
      .addr  (ram_addr),
      .we    (ram_we),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   assign depth_m2 = depth_q - D_TWO;
   assign depth_m3 = depth_q - D_THREE;
   assign is_full  = (depth_q == D_FULL);
   assign is_empty = (depth_q == '0);

   // Second operand (below top) minus/plus/times top; results wrap at DATA_W.
   always_comb begin
      case (op_q)
         OP_SUB:  alu_res = opb_q - opa_q;
         OP_MUL:  alu_res = opb_q * opa_q;
         default: alu_res = opb_q + opa_q;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         depth_q <= '0;
         top_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         op_q    <= OP_NOP;
         opa_q   <= '0;
         opb_q   <= '0;
         next_q  <= '0;
      end else begin
         state_q <= state_d;
         depth_q <= depth_d;
         top_q   <= top_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         op_q    <= op_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         next_q  <= next_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      depth_d   = depth_q;
      top_d     = top_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      op_d      = op_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      next_d    = next_q;
      ram_addr  = depth_q[PTR_W-1:0];
      ram_we    = 1'b0;
      ram_wdata = '0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_PUSH: begin
                     if (is_full) begin
                        ovf_d = 1'b1;
                     end else begin
                        ram_we    = 1'b1;
                        ram_addr  = depth_q[PTR_W-1:0];
                        ram_wdata = cmd_data;
                        depth_d   = depth_q + D_ONE;
                        top_d     = cmd_data;
                     end
                  end
                  OP_DUP: begin
                     if (is_empty) begin
                        unf_d = 1'b1;
                     end else if (is_full) begin
                        ovf_d = 1'b1;
                     end else begin
                        ram_we    = 1'b1;
                        ram_addr  = depth_q[PTR_W-1:0];
                        ram_wdata = top_q;
                        depth_d   = depth_q + D_ONE;
                     end
                  end
                  OP_POP: begin
                     if (is_empty) begin
                        unf_d = 1'b1;
                     end else begin
                        ram_addr = depth_m2[PTR_W-1:0];
                        op_d     = cmd_op;
                        state_d  = ST_RD_A;
                     end
                  end
                  OP_ADD, OP_SUB, OP_MUL: begin
                     if (depth_q < D_TWO) begin
                        unf_d = 1'b1;
                     end else begin
                        opa_d    = top_q;
                        ram_addr = depth_m2[PTR_W-1:0];
                        op_d     = cmd_op;
                        state_d  = ST_RD_A;
                     end
                  end
                  OP_CLEAR: begin
                     depth_d = '0;
                     top_d   = '0;
                     ovf_d   = 1'b0;
                     unf_d   = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
         ST_RD_A: begin
            if (op_q == OP_POP) begin
               // Popping the last entry leaves an empty stack, shown as 0.
               top_d   = (depth_q == D_ONE) ? '0 : ram_rdata;
               depth_d = depth_q - D_ONE;
               state_d = ST_IDLE;
            end else begin
               opb_d    = ram_rdata;
               ram_addr = depth_m3[PTR_W-1:0];
               state_d  = ST_RD_B;
            end
         end
         ST_RD_B: begin
            next_d  = ram_rdata;
            state_d = ST_WB;
         end
         ST_WB: begin
            ram_we    = 1'b1;
            ram_addr  = depth_m2[PTR_W-1:0];
            ram_wdata = alu_res;
            depth_d   = depth_q - D_ONE;
            top_d     = alu_res;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cmd_ready     = (state_q == ST_IDLE);
   assign top           = top_q;
   assign depth         = depth_q;
   assign err_overflow  = ovf_q;
   assign err_underflow = unf_q;
   assign dbg_state     = state_q;
   assign dbg_next      = next_q;

endmodule

// File: tb/tb_rpn_exec.sv
// Directed bench for rpn_exec: drivers queue the expected post-command state,
// a monitor pops and compares when each accepted command completes.
module tb_rpn_exec;
   import rpn_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int PW    = 4;
   localparam int EW    = 2 + PW + 1 + DW;

   logic              CLOCK_50 = 1'b0;
   logic              RESET_N  = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [2:0]        cmd_op   = OP_NOP;
   logic [DW-1:0]     cmd_data = '0;
   logic [DW-1:0]     top;
   logic [PW:0]       depth;
   logic              err_overflow;
   logic              err_underflow;
   rpn_state_t        dbg_state;
   logic [DW-1:0]     dbg_next;

   logic [EW-1:0]     exp_q[$];
   int                n_cmp = 0;
   int                n_err = 0;
   int                n_done = 0;
   bit                pending = 1'b0;

   rpn_exec #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .CLOCK_50      (CLOCK_50),
      .RESET_N       (RESET_N),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_data      (cmd_data),
      .top           (top),
      .depth         (depth),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow),
      .dbg_state     (dbg_state),
      .dbg_next      (dbg_next)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   function automatic logic [EW-1:0] pack(input int t, input int d, input int ov, input int un);
      logic [EW-1:0] v;
      v = {ov[0], un[0], d[PW:0], t[DW-1:0]};
      return v;
   endfunction

   // Monitor: a command is pending from the cycle it is accepted until the
   // first falling edge where cmd_ready is high again.
   initial begin
      logic [EW-1:0] got;
      logic [EW-1:0] e;
      forever begin
         @(negedge CLOCK_50);
         if (pending && cmd_ready) begin
            pending = 1'b0;
            n_done++;
            got = {err_overflow, err_underflow, depth, top};
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL cmd#%0d: no expected entry, got top=%0d depth=%0d ovf=%0b unf=%0b",
                        n_done, top, depth, err_overflow, err_underflow);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  n_err++;
                  $display("FAIL cmd#%0d: got top=%0d depth=%0d ovf=%0b unf=%0b, want top=%0d depth=%0d ovf=%0b unf=%0b",
                           n_done, got[DW-1:0], got[DW+PW:DW], got[EW-1], got[EW-2],
                           e[DW-1:0], e[DW+PW:DW], e[EW-1], e[EW-2]);
               end
            end
         end
         if (cmd_valid && cmd_ready && RESET_N) pending = 1'b1;
      end
   end

   task automatic check(input string name, input int act, input int want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, act, want);
      end
   endtask

   task automatic do_reset();
      cmd_valid = 1'b0;
      @(posedge CLOCK_50);
      #1 RESET_N = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      RESET_N = 1'b1;
      @(posedge CLOCK_50);
      #1;
   endtask

   // Drive one command and hold it until accepted; returns 1 ns after the accept edge.
   task automatic issue(input logic [2:0] op, input int data,
                        input int et, input int ed, input int eo, input int eu);
      bit ok;
      exp_q.push_back(pack(et, ed, eo, eu));
      cmd_op    = op;
      cmd_data  = data[DW-1:0];
      cmd_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLOCK_50);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: op=%0d not accepted, want accept within 30 cycles", op);
      end
      @(posedge CLOCK_50);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = OP_NOP;
      cmd_data  = DW'($urandom_range(0, 255));
   endtask

   // Count falling edges with cmd_ready low after an accept.
   task automatic count_busy(input string name, input int want);
      int cycles;
      cycles = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLOCK_50);
         if (cmd_ready) break;
         cycles++;
      end
      check(name, cycles, want);
      @(posedge CLOCK_50);
      #1;
   endtask

   initial begin
      bit drained;
      do_reset();
      check("rst_top", int'(top), 0);
      check("rst_depth", int'(depth), 0);
      check("rst_ovf", int'(err_overflow), 0);
      check("rst_unf", int'(err_underflow), 0);
      check("rst_ready", int'(cmd_ready), 1);
      check("rst_state", int'(dbg_state), int'(ST_IDLE));

      // 5 - 3
      issue(OP_PUSH, 5, 5, 1, 0, 0);
      issue(OP_PUSH, 3, 3, 2, 0, 0);
      issue(OP_SUB, 0, 2, 1, 0, 0);
      count_busy("sub_busy_cycles", 3);

      // Wrapping add and multiply
      issue(OP_CLEAR, 0, 0, 0, 0, 0);
      issue(OP_PUSH, 200, 200, 1, 0, 0);
      issue(OP_PUSH, 100, 100, 2, 0, 0);
      issue(OP_ADD, 0, 44, 1, 0, 0);
      count_busy("add_busy_cycles", 3);
      issue(OP_PUSH, 16, 16, 2, 0, 0);
      issue(OP_MUL, 0, 192, 1, 0, 0);
      count_busy("mul_busy_cycles", 3);

      // Fill to DEPTH back to back, then overflow and clear
      issue(OP_CLEAR, 0, 0, 0, 0, 0);
      for (int i = 1; i <= DEPTH; i++) issue(OP_PUSH, i, i, i, 0, 0);
      issue(OP_PUSH, 99, 16, 16, 1, 0);
      issue(OP_DUP, 0, 16, 16, 1, 0);
      issue(OP_CLEAR, 0, 0, 0, 0, 0);

      // Underflow on binary ops
      do_reset();
      issue(OP_ADD, 0, 0, 0, 0, 1);
      issue(OP_PUSH, 4, 4, 1, 0, 1);
      issue(OP_MUL, 0, 4, 1, 0, 1);

      // DUP / POP, including popping the last entry
      issue(OP_CLEAR, 0, 0, 0, 0, 0);
      issue(OP_PUSH, 7, 7, 1, 0, 0);
      issue(OP_PUSH, 9, 9, 2, 0, 0);
      issue(OP_DUP, 0, 9, 3, 0, 0);
      issue(OP_POP, 0, 9, 2, 0, 0);
      count_busy("pop_busy_cycles", 1);
      issue(OP_POP, 0, 7, 1, 0, 0);
      issue(OP_POP, 0, 0, 0, 0, 0);
      issue(OP_POP, 0, 0, 0, 0, 1);

      // Reset while the ADD sits in RD_B: no write-back, reset values afterwards
      issue(OP_CLEAR, 0, 0, 0, 0, 0);
      issue(OP_PUSH, 1, 1, 1, 0, 0);
      issue(OP_PUSH, 2, 2, 2, 0, 0);
      issue(OP_ADD, 0, 0, 0, 0, 0);
      @(posedge CLOCK_50);
      #1;
      check("state_before_abort", int'(dbg_state), int'(ST_RD_B));
      RESET_N = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      RESET_N = 1'b1;
      @(posedge CLOCK_50);
      #1;
      check("abort_ready", int'(cmd_ready), 1);
      check("abort_depth", int'(depth), 0);
      check("abort_top", int'(top), 0);
      issue(OP_PUSH, 6, 6, 1, 0, 0);

      drained = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLOCK_50);
         if (exp_q.size() == 0 && !pending) begin
            drained = 1'b1;
            break;
         end
      end
      if (!drained) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: %0d expected results outstanding, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rpn_exec.md
# rpn_exec

Execution stage for the RPN calculator. It consumes one command at a time (push operand, pop, dup, clear, add, sub, mul) and owns the operand stack memory and the stack pointer. The block sits between the front panel's command decoder (switch operand and key strobes) and the display logic. It presents top-of-stack, depth and sticky error flags for the HEX/LEDR drivers.

## Interface
- DATA_W, default 8: operand and result width.
- DEPTH, default 16: stack entries; a power of two; PTR_W = $clog2(DEPTH).
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_op  in  3  0 NOP, 1 PUSH, 2 POP, 3 ADD, 4 SUB, 5 MUL, 6 DUP, 7 CLEAR.
- cmd_data  in  DATA_W  operand for PUSH; ignored otherwise.
- top  out  DATA_W  cached top-of-stack; 0 when the stack is empty.
- depth  out  PTR_W+1  number of valid entries, 0..DEPTH.
- err_overflow  out  1  sticky; a PUSH or DUP was attempted while the stack was full.
- err_underflow  out  1  sticky; there were too few operands for the requested op.

## Operation
- A command is accepted on an edge where cmd_valid && cmd_ready.
- **Storage model:**
  - The RAM holds all entries at addresses 0..depth-1.
  - `top` mirrors mem[depth-1].
- **FSM states:** IDLE, RD_A, RD_B, WB.
- **Single-cycle commands** (block stays in IDLE):
  - PUSH: write cmd_data at mem[depth], depth+1, top=cmd_data.
  - DUP: write top at mem[depth], depth+1.
  - CLEAR: depth=0, top=0, both error flags cleared.
  - NOP: no effect.
- **POP:**
  - IDLE issues a read of depth-2, then goes to RD_A.
  - RD_A: top=rdata, or 0 if the old depth was 1; depth-1; go to IDLE.
- **ADD/SUB/MUL:**
  - IDLE: opA=top, issue a read of depth-2, go to RD_A.
  - RD_A: opB=rdata, issue a read of depth-3, go to RD_B.
  - RD_B: capture next = rdata, go to WB.
  - WB: result = opB op opA, written to mem[depth-2]; depth-1; top=result; go to IDLE.
- **Arithmetic:**
  - SUB is opB - opA, i.e. second minus top.
  - MUL keeps the low DATA_W bits of the product.
  - All results are modulo 2^DATA_W; there are no carry or sign flags.
- **Error cases** are consumed in one cycle in IDLE and leave stack, depth and top unchanged:
  - PUSH or DUP with depth==DEPTH sets err_overflow.
  - POP or DUP with depth==0 sets err_underflow.
  - A binary op with depth<2 sets err_underflow.
- **Error flag lifetime:** flags stay set until CLEAR or reset. Setting a flag does not block later commands.
- **Empty stack:** the depth-2 and depth-3 reads when depth<3 are don't-care addresses. Their data is never used.

## Timing
- **Reset values:** state=IDLE, depth=0, top=0, both errors=0, cmd_ready=1. RAM contents are undefined and never read before being written.
- **Reset mid-operation:** the op aborts with no write-back. Stack state goes to the reset values, and cmd_ready=1 once RESET_N is high.
- **Accept-to-accept spacing:**
  - PUSH, DUP, CLEAR, NOP and error cases: 1 cycle; back-to-back pushes are allowed every cycle.
  - POP: 2 cycles.
  - ADD/SUB/MUL: 4 cycles.
- **Output update:** top and depth change on the edge that completes the command: the accept edge for single-cycle commands, the RD_A exit for POP, the WB exit for binary ops.
- **RAM:** 1-cycle synchronous read latency. At most one access (read or write) per cycle, so there are no read/write collisions.
- **Input stability:** cmd_data and cmd_op are sampled only on the accept edge.

## Structure
- **rpn_pkg:** opcode localparams (OP_NOP..OP_CLEAR) and FSM state encodings, shared with the command decoder.
- **rpn_stack_ram:** single-port synchronous RAM, DEPTH x DATA_W.
  - Ports: clock, addr[PTR_W], we, wdata, rdata.
  - No reset.
  - Instantiated once; the FSM, pointer, top cache and ALU stay in rpn_exec.

## Test plan
- After reset: PUSH 5, PUSH 3, SUB -> top=2, depth=1. cmd_ready is low for exactly 3 cycles after the SUB accept.
- PUSH 200, PUSH 100, ADD -> top=44 (300 mod 256). Then PUSH 16, MUL -> top=192 (704 mod 256), depth=1.
- 16 back-to-back PUSHes of 1..16 with cmd_valid held high -> depth=16, top=16. A 17th PUSH 99 -> err_overflow=1, depth=16, top=16. CLEAR -> depth=0, top=0, err_overflow=0.
- After reset: ADD -> err_underflow=1, depth=0. PUSH 4, then MUL -> err_underflow stays 1, depth=1, top=4.
- PUSH 7, PUSH 9, DUP, POP, POP -> top=7, depth=1. A further POP leaves top=0, depth=0, with no error.
- PUSH 1, PUSH 2, ADD, with RESET_N pulsed low while the FSM is in RD_B -> after release: depth=0, top=0, cmd_ready=1, no write-back. A later PUSH 6 gives top=6, depth=1.
